// File: rtl/alu8_reg.sv
// Registered ALU: ripple-carry add/sub, bitwise logic units and an 8:1 result mux.
// Define ALU_FLAGS_EN to add the registered zero and signed-overflow flag outputs.

module alu8_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module alu8_ripple #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    logic [WIDTH:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        alu8_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign co = c[WIDTH];
endmodule

module alu8_logic #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_r,
    output logic [WIDTH-1:0] or_r,
    output logic [WIDTH-1:0] xor_r,
    output logic [WIDTH-1:0] not_r
);
    assign and_r = a & b;
    assign or_r  = a | b;
    assign xor_r = a ^ b;
    assign not_r = ~a;
endmodule

module alu8_mux8 #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (sel)
            3'd0:    y = d0;
            3'd1:    y = d1;
            3'd2:    y = d2;
            3'd3:    y = d3;
            3'd4:    y = d4;
            3'd5:    y = d5;
            3'd6:    y = d6;
            default: y = d7;
        endcase
    end
endmodule

module alu8_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    // Valid-only handshake: a transaction is accepted on every rising edge where
    // in_valid=1; there is no ready, so the source may issue every cycle and
    // out_valid marks the cycle after acceptance as carrying its result.

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] not_r;
    logic [WIDTH-1:0] mux_out;
    logic             carry_next;

    // SUB is a + ~b + 1, so the adder carry-out is the inverse of the borrow.
    assign is_sub = (sel == OP_SUB);
    assign b_eff  = is_sub ? ~b : b;

    alu8_ripple #(.WIDTH(WIDTH)) u_adder (
        .a   (a),
        .b   (b_eff),
        .ci  (is_sub),
        .sum (sum),
        .co  (co)
    );

    alu8_logic #(.WIDTH(WIDTH)) u_logic (
        .a     (a),
        .b     (b),
        .and_r (and_r),
        .or_r  (or_r),
        .xor_r (xor_r),
        .not_r (not_r)
    );

    alu8_mux8 #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .d0  (sum),
        .d1  (sum),
        .d2  (and_r),
        .d3  (or_r),
        .d4  (xor_r),
        .d5  (not_r),
        .d6  ({WIDTH{1'b0}}),
        .d7  ({WIDTH{1'b0}}),
        .y   (mux_out)
    );

    always_comb begin
        carry_next = 1'b0;
        case (sel)
            OP_ADD:  carry_next = co;
            OP_SUB:  carry_next = ~co;
            default: carry_next = 1'b0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic zero_next;
    logic ovf_next;

    // With b already inverted for SUB, both cases reduce to the ADD overflow rule.
    assign zero_next = (mux_out == '0);
    assign ovf_next  = ((sel == OP_ADD) || (sel == OP_SUB))
                       && (a[WIDTH-1] == b_eff[WIDTH-1])
                       && (sum[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            zero <= zero_next;
            ovf  <= ovf_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= mux_out;
                carry  <= carry_next;
            end
        end
    end
endmodule

// File: tb/tb_alu8_reg.sv
// Bench for alu8_reg: directed literal cases plus randomized traffic against a
// behavioural model; flag outputs are checked when ALU_FLAGS_EN is defined.

module tb_alu8_reg;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic       out_valid;
    logic [7:0] result;
    logic       carry;
`ifdef ALU_FLAGS_EN
    logic       zero;
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    // expected entry packing: {ovf, zero, carry, result[7:0]}
    logic [10:0] exp_q[$];
    logic [10:0] m_state;
    logic        m_valid;
    logic        chk_en = 1'b0;

    alu8_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .result    (result),
        .carry     (carry)
`ifdef ALU_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference: plain integer arithmetic on the opcode rules
    function automatic logic [10:0] ref_op(input int x, input int y, input int s);
        int   r;
        int   sx;
        int   sy;
        int   sr;
        logic c;
        logic o;
        logic [7:0] r8;
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        c  = 1'b0;
        o  = 1'b0;
        case (s)
            0: begin
                r  = x + y;
                c  = (r > 255);
                r  = r % 256;
                sr = sx + sy;
                o  = (sr > 127) || (sr < -128);
            end
            1: begin
                c  = (x < y);
                r  = (x + 256 - y) % 256;
                sr = sx - sy;
                o  = (sr > 127) || (sr < -128);
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = 255 - x;
            default: r = 0;
        endcase
        r8 = r[7:0];
        return {o, (r8 == 8'd0), c, r8};
    endfunction

    // model state advances on the same edge as the DUT
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_state = '0;
            chk_en  = 1'b1;
        end else if (chk_en) begin
            m_valid = in_valid;
            if (in_valid) m_state = ref_op(int'(a), int'(b), int'(sel));
        end
    end

    // compare process: model every cycle, scoreboard on each valid output
    always @(negedge clk) begin
        logic [10:0] e;
        if (chk_en) begin
            check("model_valid", int'(out_valid), int'(m_valid));
            check("model_result", int'(result), int'(m_state[7:0]));
            check("model_carry", int'(carry), int'(m_state[8]));
`ifdef ALU_FLAGS_EN
            check("model_zero", int'(zero), int'(m_state[9]));
            check("model_ovf", int'(ovf), int'(m_state[10]));
`endif
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", int'(result), int'(e[7:0]));
                    check("sb_carry", int'(carry), int'(e[8]));
`ifdef ALU_FLAGS_EN
                    check("sb_zero", int'(zero), int'(e[9]));
                    check("sb_ovf", int'(ovf), int'(e[10]));
`endif
                end
            end
        end
    end

    // driver tasks
    task automatic lit_op(input int x, input int y, input int s,
                          input int er, input int ec, input int eo);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'(x);
        b        = 8'(y);
        sel      = 3'(s);
        exp_q.push_back({1'(eo), 1'(er == 0), 1'(ec), 8'(er)});
    endtask

    task automatic idle_chk(input int held);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'($urandom_range(0, 255));
        b        = 8'($urandom_range(0, 255));
        sel      = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_result_held", int'(result), held);
    endtask

    task automatic rand_op();
        @(negedge clk);
        in_valid = ($urandom_range(0, 9) < 8);
        a        = 8'($urandom_range(0, 255));
        b        = 8'($urandom_range(0, 255));
        sel      = 3'($urandom_range(0, 7));
        if (in_valid) exp_q.push_back(ref_op(int'(a), int'(b), int'(sel)));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 8'd5;
        b        = 8'd3;
        sel      = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_result", int'(result), 0);
        check("reset_carry", int'(carry), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // back-to-back literal cases
        lit_op(5, 3, 0, 8, 0, 0);
        lit_op(23, 11, 0, 34, 0, 0);
        lit_op(200, 100, 0, 44, 1, 0);
        lit_op(255, 1, 0, 0, 1, 0);
        lit_op(5, 3, 1, 2, 0, 0);
        lit_op(23, 11, 1, 12, 0, 0);
        lit_op(3, 5, 1, 254, 1, 0);
        lit_op(0, 1, 1, 255, 1, 0);
        lit_op(5, 3, 2, 1, 0, 0);
        lit_op(23, 11, 2, 3, 0, 0);
        lit_op(5, 3, 3, 7, 0, 0);
        lit_op(23, 11, 3, 31, 0, 0);
        lit_op(5, 3, 4, 6, 0, 0);
        lit_op(23, 11, 4, 28, 0, 0);
        lit_op(5, 3, 5, 250, 0, 0);
        lit_op(23, 11, 5, 232, 0, 0);
        lit_op(23, 11, 6, 0, 0, 0);
        lit_op(23, 11, 7, 0, 0, 0);
        lit_op(100, 50, 0, 150, 0, 1);
        lit_op(5, 5, 1, 0, 0, 0);
        lit_op(128, 1, 1, 127, 0, 1);
        idle_chk(127);
        idle_chk(127);

        // reset in the middle of traffic
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_result", int'(result), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        lit_op(0, 0, 5, 255, 0, 0);

        repeat (400) rand_op();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
